// File: rtl/data_block_pkg.sv
// Shared widths, types and helpers for the cipher data block buffer.
package data_block_pkg;

    localparam int DATA_BLOCK_W   = 128;
    localparam int DATA_MEM_DEPTH = 32;

    typedef logic [DATA_BLOCK_W-1:0] data_block_t;

    // The head of the queue comes either from the write bypass or from the RAM read port.
    typedef enum logic {
        HEAD_BYPASS = 1'b0,
        HEAD_RAM    = 1'b1
    } head_src_e;

    // The level counter must hold 0..depth inclusive, so it needs one bit more than the pointers.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/data_block_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no reset.
module data_block_ram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    // The read register only updates on rd_en so it holds the head while the consumer stalls.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rdData_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/data_block_fifo.sv
// First-word-fall-through buffer for cipher data blocks with exact level,
// almost-full/almost-empty thresholds, sticky error flags and a synchronous flush.
module data_block_fifo
    import data_block_pkg::*;
#(
    parameter int DATA_W   = DATA_BLOCK_W,
    parameter int DEPTH    = DATA_MEM_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 2,
    parameter int LVL_W    = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_LEVEL);

    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              rdValid_q, rdValid_d;
    logic [DATA_W-1:0] bypass_q, bypass_d;
    head_src_e         headSel_q, headSel_d;
    logic              almostFull_q, almostFull_d;
    logic              almostEmpty_q, almostEmpty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              push;
    logic              pop;
    logic              levelIsOne;
    logic              ramWe;
    logic              ramRe;
    logic [DATA_W-1:0] ramRdData;

    assign wr_ready   = (level_q != LVL_FULL);
    assign push       = wr_valid & wr_ready;
    assign pop        = rdValid_q & rd_ready;
    assign levelIsOne = (level_q == LVL_ONE);

    // The RAM only holds the blocks behind the head, so its read and write
    // addresses never collide: a write lands at rdPtr only when the RAM is empty,
    // and then the head is refilled through the bypass instead of a RAM read.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        rdValid_d = rdValid_q;
        bypass_d  = bypass_q;
        headSel_d = headSel_q;
        ramWe     = 1'b0;
        ramRe     = 1'b0;

        if (flush) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            level_d   = '0;
            rdValid_d = 1'b0;
        end else begin
            if (push && (!rdValid_q || (pop && levelIsOne))) begin
                bypass_d  = wr_data;
                headSel_d = HEAD_BYPASS;
                rdValid_d = 1'b1;
            end else if (push) begin
                ramWe   = 1'b1;
                wrPtr_d = wrPtr_q + 1'b1;
            end

            if (pop && !levelIsOne) begin
                ramRe     = 1'b1;
                rdPtr_d   = rdPtr_q + 1'b1;
                headSel_d = HEAD_RAM;
            end else if (pop && !push) begin
                rdValid_d = 1'b0;
            end

            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Threshold flags follow next-level so they line up with level itself;
    // a set event on the sticky flags overrides a same-cycle clear.
    always_comb begin
        almostFull_d  = (level_d >= LVL_AF);
        almostEmpty_d = (level_d <= LVL_AE);

        overflow_d = overflow_q;
        if (clear_err) begin
            overflow_d = 1'b0;
        end
        if (wr_valid && !wr_ready && !flush) begin
            overflow_d = 1'b1;
        end

        underflow_d = underflow_q;
        if (clear_err) begin
            underflow_d = 1'b0;
        end
        if (rd_ready && !rdValid_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            level_q       <= '0;
            rdValid_q     <= 1'b0;
            bypass_q      <= '0;
            headSel_q     <= HEAD_BYPASS;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            level_q       <= level_d;
            rdValid_q     <= rdValid_d;
            bypass_q      <= bypass_d;
            headSel_q     <= headSel_d;
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    data_block_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) uRam (
        .clk       (clk),
        .wr_en_i   (ramWe),
        .wr_addr_i (wrPtr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (ramRe),
        .rd_addr_i (rdPtr_q),
        .rd_data_o (ramRdData)
    );

    // Both mux inputs are registers, so the head is stable while the consumer stalls.
    assign rd_data      = (headSel_q == HEAD_RAM) ? ramRdData : bypass_q;
    assign rd_valid     = rdValid_q;
    assign level        = level_q;
    assign almost_full  = almostFull_q;
    assign almost_empty = almostEmpty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_data_block_fifo.sv
// Scoreboard bench for data_block_fifo: a queue model tracks contents, level and flags.
module tb_data_block_fifo;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 32;
    localparam int LVL_W  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic [LVL_W-1:0]  level;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              clear_err;

    logic [DATA_W-1:0] scoreQ [$];
    logic              expOverflow;
    logic              expUnderflow;
    int                compareCount;
    int                mismatchCount;

    data_block_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (DEPTH - 4),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_err    (clear_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkState();
        int sz = scoreQ.size();
        checkOutput("level", level, DATA_W'(sz));
        checkOutput("rd_valid", rd_valid, DATA_W'(sz != 0));
        checkOutput("wr_ready", wr_ready, DATA_W'(sz != DEPTH));
        checkOutput("almost_full", almost_full, DATA_W'(sz >= DEPTH - 4));
        checkOutput("almost_empty", almost_empty, DATA_W'(sz <= 2));
        checkOutput("overflow", overflow, DATA_W'(expOverflow));
        checkOutput("underflow", underflow, DATA_W'(expUnderflow));
        if (sz != 0) begin
            checkOutput("head", rd_data, scoreQ[0]);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_valid"}, rd_valid, '0);
        checkOutput({tag, "_rd_data"}, rd_data, '0);
        checkOutput({tag, "_level"}, level, '0);
        checkOutput({tag, "_wr_ready"}, wr_ready, DATA_W'(1));
        checkOutput({tag, "_almost_full"}, almost_full, '0);
        checkOutput({tag, "_almost_empty"}, almost_empty, DATA_W'(1));
        checkOutput({tag, "_overflow"}, overflow, '0);
        checkOutput({tag, "_underflow"}, underflow, '0);
    endtask

    // One clock of stimulus: the model decides push/pop from its own level, compares
    // a popped block against the queue front, then checks all outputs after the edge.
    task automatic applyStimulus(input logic wv, input logic [DATA_W-1:0] wd,
                                 input logic rr, input logic fl, input logic ce);
        int   sz = scoreQ.size();
        logic mPush;
        logic mPop;
        logic [DATA_W-1:0] expHead;
        wr_valid  = wv;
        wr_data   = wd;
        rd_ready  = rr;
        flush     = fl;
        clear_err = ce;
        mPush = wv && !fl && (sz < DEPTH);
        mPop  = rr && !fl && (sz > 0);
        if (mPop) begin
            expHead = scoreQ.pop_front();
            checkOutput("pop_data", rd_data, expHead);
        end
        if (fl) scoreQ.delete();
        if (mPush) scoreQ.push_back(wd);
        if (ce) begin
            expOverflow  = 1'b0;
            expUnderflow = 1'b0;
        end
        if (wv && !fl && sz == DEPTH) expOverflow = 1'b1;
        if (rr && sz == 0) expUnderflow = 1'b1;
        @(posedge clk);
        #1;
        checkState();
    endtask

    function automatic logic [DATA_W-1:0] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DATA_W-1:0] blk;
        compareCount  = 0;
        mismatchCount = 0;
        expOverflow   = 1'b0;
        expUnderflow  = 1'b0;
        reset     = 1'b0;
        flush     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        clear_err = 1'b0;

        #12;
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] three pushes with consumer stalled");
        for (int i = 1; i <= 3; i++) begin
            blk = {{31{4'hA}}, 4'(i)};
            applyStimulus(1'b1, blk, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] fill to full, overflow, drain");
        for (int i = 3; i < DEPTH; i++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("[TB] underflow and clear_err");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] streaming at level one");
        applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, randBlock(), 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("[TB] pointer wrap at level five");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, randBlock(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("[TB] flush at level ten with concurrent push");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randBlock(), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randBlock(), 1'b1, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randBlock(), 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("async_reset");
        scoreQ.delete();
        expOverflow  = 1'b0;
        expUnderflow = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, randBlock(), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randBlock(), 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
